pram_wr_arbiter: RTL and testbench
==================================

# pram_wr_arbiter

N-port write arbiter between the processor cores and the data-memory write handler. It grants one requesting port at a time and forwards that port's doubleword, address and data type to memory. It holds the grant until memory has accepted the write and returned to idle. It generalises the two-processor write synchroniser to `NUM_PORTS` ports, adds round-robin fairness, and adds an explicit accept/busy handshake so a grant can never be released before memory has started the write.

## Interface
- `NUM_PORTS`, 4: number of requesting ports (2..8).
- `DOUBLEWORD_WIDTH`, 64: write data width.
- `DATA_MEMORY_SIZE`, 1024: data memory size in bytes.
- `ADDR_WIDTH_DM`, `$clog2(DATA_MEMORY_SIZE)`: write address width.
- `DATA_TYPE_WIDTH`, 2: access-size code width.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `data_bus_wr_p` in `NUM_PORTS*DOUBLEWORD_WIDTH`: per-port write data; port i occupies slice i.
- `addr_wr_p` in `NUM_PORTS*ADDR_WIDTH_DM`: per-port address.
- `data_type_wr_p` in `NUM_PORTS*DATA_TYPE_WIDTH`: per-port data type.
- `wr_ins_p` in `NUM_PORTS`: per-port write request; the requester holds it until its `wr_access_p` bit is seen.
- `wr_idle_p` out `NUM_PORTS`: per-port idle view.
- `wr_access_p` out `NUM_PORTS`: one-hot grant (registered).
- `data_bus_wr_dm` out `DOUBLEWORD_WIDTH`, `addr_wr_dm` out `ADDR_WIDTH_DM`, `data_type_wr_dm` out `DATA_TYPE_WIDTH`: fields muxed from the granted port.
- `wr_ins_dm` out 1: write strobe to memory.
- `wr_idle_dm` in 1: memory write handler idle. It drops the cycle after it accepts a write and rises when the write completes.

## Operation
- State machine with three states:
  - IDLE: no grant is held. If any `wr_ins_p` bit is set, the arbiter picks a winner, loads `grant_idx`, sets that `wr_access_p` bit, and moves to ISSUE.
  - ISSUE: `wr_ins_dm` = `wr_ins_p[grant_idx]`.
    - If `wr_ins_dm` and `wr_idle_dm` are both high, memory has accepted: move to BUSY.
    - If `wr_ins_p[grant_idx]` drops before acceptance: abort, clear the grant, return to IDLE.
  - BUSY: `wr_ins_dm` = 0. When `wr_idle_dm` = 1, clear the grant, update the round-robin pointer to `grant_idx`, and return to IDLE.
- Muxed outputs always select `grant_idx`, including while in IDLE.
- `wr_idle_p[i]` = `wr_idle_dm` if bit i is granted, else 1.
- Round robin: the search starts at `last_idx+1` and wraps modulo `NUM_PORTS`. `last_idx` resets to `NUM_PORTS-1`, so port 0 wins first.
- An aborted grant does not advance `last_idx`.
- New requests arriving during ISSUE or BUSY are ignored until the machine is back in IDLE.
- At most one `wr_access_p` bit is high at any time.

## Timing
- Reset values: state = IDLE, `wr_access_p` = 0, `grant_idx` = 0, `last_idx` = `NUM_PORTS-1`, `wr_ins_dm` = 0, `wr_idle_p` = all 1. The data/address/type outputs show port 0's fields.
- Grant latency: a request seen at edge N produces `wr_access_p` high after edge N. That port's `wr_ins_dm` is visible in the same cycle.
- Minimum occupancy is 3 cycles (IDLE→ISSUE→BUSY→IDLE) plus however long memory stays busy.
- Back-to-back: a new grant can be issued on the edge after IDLE is re-entered, so there is one dead cycle between grants.
- Reset asserted mid-operation: all outputs return to their reset values immediately (asynchronous). No partial strobe is generated after reset deasserts.

## Configuration
- `PRAM_ARB_ROUND_ROBIN_EN`:
  - Defined: round-robin arbitration as described under Operation.
  - Undefined: fixed priority, lowest index wins; `last_idx` logic is compiled out.

## Structure
- Package `pram_arb_pkg`: state enum (IDLE, ISSUE, BUSY) and the default width constants.
- Sub-module `pram_rr_picker`: combinational picker. Inputs are the request vector and `last_idx`; outputs are the winner index and a valid flag. The fixed-priority variant is selected inside it by the macro.

## Test plan
- Single port: `NUM_PORTS`=4, port 2 requests addr 0x10, data 0xDEAD. Required: `wr_access_p`=0100 one cycle later, `addr_wr_dm`=0x10, one accepted strobe, grant cleared when `wr_idle_dm` returns high.
- All four ports request continuously from reset with round robin enabled. Required: grant order 0,1,2,3,0; each grant sees exactly one memory accept.
- Same stimulus with the macro undefined. Required: port 0 is granted every time while it keeps requesting.
- Memory stalls: `wr_idle_dm` held low for 10 cycles after accept. Required: grant held throughout, `wr_idle_p` of the granted port = 0, all other ports read 1.
- Abort: port 1 is granted while `wr_idle_dm`=0, then drops `wr_ins_p` before acceptance. Required: return to IDLE, no strobe accepted, next grant goes to port 1 if it requests again.
- Assert `rst` while in BUSY. Required: `wr_access_p`=0 and `wr_ins_dm`=0 within the same cycle; after release, port 0 has first priority again.

Source files
------------

// File: rtl/pram_arb_pkg.sv
// Shared state encoding, default widths and a small sizing helper for the
// N-port data-memory write arbiter.
package pram_arb_pkg;

  localparam int DEF_NUM_PORTS        = 4;
  localparam int DEF_DOUBLEWORD_WIDTH = 64;
  localparam int DEF_DATA_MEMORY_SIZE = 1024;
  localparam int DEF_DATA_TYPE_WIDTH  = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    BUSY  = 2'd2
  } arb_state_e;

  // Plain vectors keep the state register readable by older tools and scripts.
  localparam logic [1:0] ST_IDLE  = IDLE;
  localparam logic [1:0] ST_ISSUE = ISSUE;
  localparam logic [1:0] ST_BUSY  = BUSY;

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/pram_wr_arbiter_if.sv
// Bundle of the per-port request side and the memory write-handler side of the
// write arbiter. master = cores/memory environment, slave = the arbiter.
interface pram_wr_arbiter_if
  import pram_arb_pkg::*;
#(
  parameter int NUM_PORTS        = DEF_NUM_PORTS,
  parameter int DOUBLEWORD_WIDTH = DEF_DOUBLEWORD_WIDTH,
  parameter int ADDR_WIDTH_DM    = $clog2(DEF_DATA_MEMORY_SIZE),
  parameter int DATA_TYPE_WIDTH  = DEF_DATA_TYPE_WIDTH
);

  logic [NUM_PORTS*DOUBLEWORD_WIDTH-1:0] data_bus_wr_p;
  logic [NUM_PORTS*ADDR_WIDTH_DM-1:0]    addr_wr_p;
  logic [NUM_PORTS*DATA_TYPE_WIDTH-1:0]  data_type_wr_p;
  logic [NUM_PORTS-1:0]                  wr_ins_p;
  logic [NUM_PORTS-1:0]                  wr_idle_p;
  logic [NUM_PORTS-1:0]                  wr_access_p;

  logic [DOUBLEWORD_WIDTH-1:0]           data_bus_wr_dm;
  logic [ADDR_WIDTH_DM-1:0]              addr_wr_dm;
  logic [DATA_TYPE_WIDTH-1:0]            data_type_wr_dm;
  logic                                  wr_ins_dm;
  logic                                  wr_idle_dm;

  modport master (
    output data_bus_wr_p, addr_wr_p, data_type_wr_p, wr_ins_p, wr_idle_dm,
    input  wr_idle_p, wr_access_p, data_bus_wr_dm, addr_wr_dm, data_type_wr_dm, wr_ins_dm
  );

  modport slave (
    input  data_bus_wr_p, addr_wr_p, data_type_wr_p, wr_ins_p, wr_idle_dm,
    output wr_idle_p, wr_access_p, data_bus_wr_dm, addr_wr_dm, data_type_wr_dm, wr_ins_dm
  );

endinterface

// File: rtl/pram_rr_picker.sv
// Combinational winner selection for the write arbiter. Round robin starting
// after last_idx when PRAM_ARB_ROUND_ROBIN_EN is defined, else lowest index wins.
module pram_rr_picker
  import pram_arb_pkg::*;
#(
  parameter int NUM_PORTS = DEF_NUM_PORTS,
  parameter int IDX_W     = idx_width(NUM_PORTS)
) (
  input  logic [NUM_PORTS-1:0] req,
  input  logic [IDX_W-1:0]     last_idx,
  output logic [IDX_W-1:0]     win_idx,
  output logic                 win_valid
);

`ifdef PRAM_ARB_ROUND_ROBIN_EN
  // Scan from farthest to nearest so the port right after last_idx ends up winning.
  always_comb begin
    int cand;
    cand      = 0;
    win_idx   = '0;
    win_valid = 1'b0;
    for (int k = NUM_PORTS; k >= 1; k--) begin
      cand = (int'(last_idx) + k) % NUM_PORTS;
      if (req[cand]) begin
        win_idx   = IDX_W'(cand);
        win_valid = 1'b1;
      end
    end
  end
`else
  logic unused_last_idx;
  assign unused_last_idx = ^last_idx;

  always_comb begin
    win_idx   = '0;
    win_valid = 1'b0;
    for (int i = NUM_PORTS - 1; i >= 0; i--) begin
      if (req[i]) begin
        win_idx   = IDX_W'(i);
        win_valid = 1'b1;
      end
    end
  end
`endif

endmodule

// File: rtl/pram_wr_arbiter.sv
// N-port write arbiter in front of the data-memory write handler; holds one grant
// until memory has accepted and finished the write. Macro: PRAM_ARB_ROUND_ROBIN_EN.
module pram_wr_arbiter
  import pram_arb_pkg::*;
#(
  parameter int NUM_PORTS        = DEF_NUM_PORTS,
  parameter int DOUBLEWORD_WIDTH = DEF_DOUBLEWORD_WIDTH,
  parameter int DATA_MEMORY_SIZE = DEF_DATA_MEMORY_SIZE,
  parameter int ADDR_WIDTH_DM    = $clog2(DATA_MEMORY_SIZE),
  parameter int DATA_TYPE_WIDTH  = DEF_DATA_TYPE_WIDTH
) (
  input  logic              clk,
  input  logic              rst,
  pram_wr_arbiter_if.slave  bus
);

  localparam int IDX_W = idx_width(NUM_PORTS);

  logic [1:0]                  state;
  logic [IDX_W-1:0]            grant_idx;
  logic [IDX_W-1:0]            last_idx;
  logic [NUM_PORTS-1:0]        wr_access_q;
  logic [IDX_W-1:0]            win_idx;
  logic                        win_valid;
  logic [NUM_PORTS-1:0]        win_onehot;
  logic                        req_sel;
  logic                        write_done;
  logic [DOUBLEWORD_WIDTH-1:0] data_sel;
  logic [ADDR_WIDTH_DM-1:0]    addr_sel;
  logic [DATA_TYPE_WIDTH-1:0]  type_sel;

  pram_rr_picker #(
    .NUM_PORTS (NUM_PORTS),
    .IDX_W     (IDX_W)
  ) u_picker (
    .req       (bus.wr_ins_p),
    .last_idx  (last_idx),
    .win_idx   (win_idx),
    .win_valid (win_valid)
  );

  assign win_onehot = {{(NUM_PORTS-1){1'b0}}, 1'b1} << win_idx;
  assign write_done = (state == ST_BUSY) && bus.wr_idle_dm;

  // Field mux follows grant_idx in every state, so port 0 shows after reset.
  always_comb begin
    req_sel  = bus.wr_ins_p[0];
    data_sel = bus.data_bus_wr_p[DOUBLEWORD_WIDTH-1:0];
    addr_sel = bus.addr_wr_p[ADDR_WIDTH_DM-1:0];
    type_sel = bus.data_type_wr_p[DATA_TYPE_WIDTH-1:0];
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (grant_idx == IDX_W'(i)) begin
        req_sel  = bus.wr_ins_p[i];
        data_sel = bus.data_bus_wr_p[i*DOUBLEWORD_WIDTH +: DOUBLEWORD_WIDTH];
        addr_sel = bus.addr_wr_p[i*ADDR_WIDTH_DM +: ADDR_WIDTH_DM];
        type_sel = bus.data_type_wr_p[i*DATA_TYPE_WIDTH +: DATA_TYPE_WIDTH];
      end
    end
  end

  // New requests only matter in IDLE; the grant drops on abort or write completion.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_IDLE;
      grant_idx   <= '0;
      wr_access_q <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (win_valid) begin
            grant_idx   <= win_idx;
            wr_access_q <= win_onehot;
            state       <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          if (!req_sel) begin
            wr_access_q <= '0;
            state       <= ST_IDLE;
          end else if (bus.wr_idle_dm) begin
            state <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          if (bus.wr_idle_dm) begin
            wr_access_q <= '0;
            state       <= ST_IDLE;
          end
        end
        default: begin
          wr_access_q <= '0;
          state       <= ST_IDLE;
        end
      endcase
    end
  end

`ifdef PRAM_ARB_ROUND_ROBIN_EN
  // Only completed writes move the fairness pointer; aborts leave it alone.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_idx <= IDX_W'(NUM_PORTS - 1);
    end else if (write_done) begin
      last_idx <= grant_idx;
    end
  end
`else
  assign last_idx = '0;
`endif

  assign bus.wr_access_p     = wr_access_q;
  assign bus.wr_ins_dm       = (state == ST_ISSUE) && req_sel;
  assign bus.wr_idle_p       = ~wr_access_q | {NUM_PORTS{bus.wr_idle_dm}};
  assign bus.data_bus_wr_dm  = data_sel;
  assign bus.addr_wr_dm      = addr_sel;
  assign bus.data_type_wr_dm = type_sel;

endmodule

// File: tb/tb_pram_wr_arbiter.sv
// Scoreboard bench for pram_wr_arbiter: directed requests push expected memory
// writes, a monitor checks every accepted strobe. Honours PRAM_ARB_ROUND_ROBIN_EN.
module tb_pram_wr_arbiter;
  import pram_arb_pkg::*;

  localparam int NP = 4;
  localparam int DW = 64;
  localparam int MS = 1024;
  localparam int AW = 10;
  localparam int TW = 2;

  typedef struct {
    int            port;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic [TW-1:0] dtype;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  pram_wr_arbiter_if #(
    .NUM_PORTS(NP), .DOUBLEWORD_WIDTH(DW), .ADDR_WIDTH_DM(AW), .DATA_TYPE_WIDTH(TW)
  ) bus ();

  pram_wr_arbiter #(
    .NUM_PORTS(NP), .DOUBLEWORD_WIDTH(DW), .DATA_MEMORY_SIZE(MS),
    .ADDR_WIDTH_DM(AW), .DATA_TYPE_WIDTH(TW)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  exp_t          exp_q[$];
  logic [AW-1:0] port_addr [NP];
  logic [DW-1:0] port_data [NP];
  logic [TW-1:0] port_type [NP];
  int   checks = 0;
  int   errors = 0;
  int   accept_cnt = 0;
  int   stall_cycles = 1;
  logic mem_hold_low = 1'b0;
  int   n_wait;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic setPort(input int p, input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [TW-1:0] t);
    port_addr[p] = a;
    port_data[p] = d;
    port_type[p] = t;
    bus.addr_wr_p[p*AW +: AW]      = a;
    bus.data_bus_wr_p[p*DW +: DW]  = d;
    bus.data_type_wr_p[p*TW +: TW] = t;
  endtask

  task automatic pushExp(input int p);
    exp_t e;
    e.port  = p;
    e.addr  = port_addr[p];
    e.data  = port_data[p];
    e.dtype = port_type[p];
    exp_q.push_back(e);
  endtask

  task automatic applyStimulus(input logic [NP-1:0] req);
    bus.wr_ins_p = req;
  endtask

  task automatic waitAccepts(input int target, input int budget);
    int n;
    n = 0;
    while (accept_cnt < target && n < budget) begin
      tick();
      n++;
    end
    checkOutput("accept_timeout", 64'(accept_cnt >= target), 64'(1));
  endtask

  task automatic waitRelease(input int budget, output int n);
    n = 0;
    while (bus.wr_access_p != '0 && n < budget) begin
      tick();
      n++;
    end
    checkOutput("grant_release", 64'(bus.wr_access_p), 64'(0));
  endtask

  // Memory write handler: idle drops after an accept and returns after stall_cycles.
  initial begin
    int   cnt;
    logic acc;
    cnt = 0;
    bus.wr_idle_dm = 1'b1;
    forever begin
      @(negedge clk);
      acc = bus.wr_ins_dm && bus.wr_idle_dm;
      @(posedge clk);
      #1;
      if (rst)           cnt = 0;
      else if (acc)      cnt = stall_cycles;
      else if (cnt > 0)  cnt--;
      bus.wr_idle_dm = (cnt == 0) && !mem_hold_low;
    end
  end

  // Monitor: every accepted strobe must match the oldest expected write.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      checkOutput("onehot_grant", 64'($countones(bus.wr_access_p) > 1), 64'(0));
      if (!rst && bus.wr_ins_dm && bus.wr_idle_dm) begin
        accept_cnt++;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected_accept: grant %b, expected no write", bus.wr_access_p);
        end else begin
          e = exp_q.pop_front();
          checkOutput("accept_grant", 64'(bus.wr_access_p), 64'(1) << e.port);
          checkOutput("accept_addr",  64'(bus.addr_wr_dm), 64'(e.addr));
          checkOutput("accept_data",  bus.data_bus_wr_dm, e.data);
          checkOutput("accept_type",  64'(bus.data_type_wr_dm), 64'(e.dtype));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not complete");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int exp_order [5];
    rst = 1'b1;
    bus.wr_ins_p = '0;
    for (int p = 0; p < NP; p++)
      setPort(p, AW'(10'h100 + p * 8), 64'hA5A5_0000_0000_0000 + 64'(p), TW'(p));
    repeat (3) tick();

    checkOutput("rst_access",  64'(bus.wr_access_p), 64'(0));
    checkOutput("rst_strobe",  64'(bus.wr_ins_dm), 64'(0));
    checkOutput("rst_idle_p",  64'(bus.wr_idle_p), 64'hF);
    checkOutput("rst_addr",    64'(bus.addr_wr_dm), 64'h100);
    checkOutput("rst_data",    bus.data_bus_wr_dm, 64'hA5A5_0000_0000_0000);
    rst = 1'b0;
    tick();

    $display("[TB] single port write from port 2");
    stall_cycles = 3;
    setPort(2, 10'h010, 64'hDEAD, 2'b11);
    pushExp(2);
    applyStimulus(4'b0100);
    tick();
    checkOutput("t1_grant",  64'(bus.wr_access_p), 64'h4);
    checkOutput("t1_addr",   64'(bus.addr_wr_dm), 64'h10);
    checkOutput("t1_strobe", 64'(bus.wr_ins_dm), 64'(1));
    tick();
    applyStimulus(4'b0000);
    checkOutput("t1_busy_grant",  64'(bus.wr_access_p), 64'h4);
    checkOutput("t1_busy_strobe", 64'(bus.wr_ins_dm), 64'(0));
    checkOutput("t1_idle_p",      64'(bus.wr_idle_p), 64'hB);
    waitRelease(20, n_wait);
    checkOutput("t1_busy_len", 64'(n_wait), 64'(4));
    checkOutput("t1_queue", 64'(exp_q.size()), 64'(0));
    tick();

    $display("[TB] memory stall of 10 cycles on port 3");
    stall_cycles = 10;
    pushExp(3);
    applyStimulus(4'b1000);
    tick();
    tick();
    applyStimulus(4'b0000);
    for (int k = 0; k < 10; k++) begin
      checkOutput("t2_hold_grant", 64'(bus.wr_access_p), 64'h8);
      checkOutput("t2_idle_p",     64'(bus.wr_idle_p), 64'h7);
      tick();
    end
    waitRelease(5, n_wait);
    checkOutput("t2_release_len", 64'(n_wait), 64'(1));
    tick();

    $display("[TB] all ports requesting from reset");
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    tick();
    stall_cycles = 1;
`ifdef PRAM_ARB_ROUND_ROBIN_EN
    exp_order = '{0, 1, 2, 3, 0};
`else
    exp_order = '{0, 0, 0, 0, 0};
`endif
    foreach (exp_order[i]) pushExp(exp_order[i]);
    applyStimulus(4'b1111);
    waitAccepts(accept_cnt + 5, 100);
    applyStimulus(4'b0000);
    waitRelease(20, n_wait);
    checkOutput("t3_queue", 64'(exp_q.size()), 64'(0));
    tick();

    $display("[TB] abort on port 1 while memory is busy");
    mem_hold_low = 1'b1;
    tick();
    applyStimulus(4'b0010);
    tick();
    checkOutput("t4_grant",  64'(bus.wr_access_p), 64'h2);
    checkOutput("t4_strobe", 64'(bus.wr_ins_dm), 64'(1));
    tick();
    checkOutput("t4_wait_grant", 64'(bus.wr_access_p), 64'h2);
    applyStimulus(4'b0000);
    tick();
    checkOutput("t4_abort_grant",  64'(bus.wr_access_p), 64'(0));
    checkOutput("t4_abort_strobe", 64'(bus.wr_ins_dm), 64'(0));
    mem_hold_low = 1'b0;
    tick();
    pushExp(1);
    applyStimulus(4'b0110);
    tick();
    checkOutput("t4_regrant", 64'(bus.wr_access_p), 64'h2);
    waitAccepts(accept_cnt + 1, 20);
    applyStimulus(4'b0000);
    waitRelease(20, n_wait);
    tick();

    $display("[TB] reset asserted during BUSY");
    stall_cycles = 8;
    pushExp(2);
    applyStimulus(4'b0100);
    tick();
    tick();
    applyStimulus(4'b0000);
    tick();
    checkOutput("t5_busy_grant", 64'(bus.wr_access_p), 64'h4);
    #1 rst = 1'b1;
    #1;
    checkOutput("t5_rst_grant",  64'(bus.wr_access_p), 64'(0));
    checkOutput("t5_rst_strobe", 64'(bus.wr_ins_dm), 64'(0));
    checkOutput("t5_rst_idle_p", 64'(bus.wr_idle_p), 64'hF);
    tick();
    tick();
    rst = 1'b0;
    tick();
    checkOutput("t5_post_grant",  64'(bus.wr_access_p), 64'(0));
    checkOutput("t5_post_strobe", 64'(bus.wr_ins_dm), 64'(0));
    pushExp(0);
    applyStimulus(4'b1111);
    tick();
    checkOutput("t5_first_grant", 64'(bus.wr_access_p), 64'h1);
    waitAccepts(accept_cnt + 1, 20);
    applyStimulus(4'b0000);
    waitRelease(20, n_wait);
    repeat (3) tick();

    checkOutput("final_queue", 64'(exp_q.size()), 64'(0));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
